// File: rtl/ball_spawn_ctrl.sv
// Ball slot manager: splits a rope-hit ball into two children and strobes the movers' load inputs.
// Optional feature: define BALL_SPAWN_SCORE_EN to build the saturating level-0 pop counter.
module ball_spawn_ctrl #(
  parameter int NUM_SLOTS    = 4,
  parameter int MAX_LEVEL    = 3,
  parameter int START_X      = 100,
  parameter int START_Y      = 100,
  parameter int START_XSPEED = 64,
  parameter int START_YSPEED = 0,
  parameter int SPLIT_XSPEED = 96,
  parameter int SPLIT_YSPEED = -200,
  parameter int CHILD_OFFSET = 24,
  parameter int X_MAX        = 599
) (
  input  logic                   clk,
  input  logic                   resetN,
  input  logic                   startOfFrame,
  input  logic                   restart,
  input  logic                   hitValid,
  input  logic [2:0]             hitSlot,
  input  logic [10:0]            hitX,
  input  logic [10:0]            hitY,
  output logic [NUM_SLOTS-1:0]   loadN,
  output logic [10:0]            initialX,
  output logic [10:0]            initialY,
  output logic signed [15:0]     initialXspeed,
  output logic signed [15:0]     initialYspeed,
  output logic [NUM_SLOTS-1:0]   slotActive,
  output logic [2*NUM_SLOTS-1:0] slotLevel,
  output logic                   busy,
  output logic                   allCleared,
  output logic [15:0]            popCount
);
  localparam int LW = 2 * NUM_SLOTS;

  typedef enum logic [1:0] {IDLE, LOAD_L, LOAD_R, RESTART} state_t;

  state_t                state_r, next_state_s;
  logic [NUM_SLOTS-1:0]  load_n_r, active_r, pop_mask_s;
  logic [LW-1:0]         level_r;
  logic [10:0]           x_r, y_r, hit_x_r, hit_y_r, right_x_s;
  logic signed [15:0]    xs_r, ys_r;
  logic                  busy_r, all_cleared_r;
  logic [1:0]            child_level_r, hit_level_s;
  logic [7:0]            active_ext_s;
  logic [15:0]           level_ext_s;
  logic                  hit_ok_s, do_restart_s, do_pop_s, do_split_s, free_found_s;
  logic [2:0]            free_idx_s;
  logic [11:0]           x_sum_s;
  logic                  unused_s;

  assign unused_s = startOfFrame;

  function automatic logic [LW-1:0] set_level(input logic [LW-1:0] lv, input logic [2:0] idx,
                                              input logic [1:0] val);
    set_level = (lv & ~(LW'(2'd3) << {idx, 1'b0})) | (LW'(val) << {idx, 1'b0});
  endfunction

  // Request decode, free-slot search and right-child X clamp
  always_comb begin
    active_ext_s = 8'(active_r);
    level_ext_s  = 16'(level_r);
    hit_level_s  = level_ext_s[{hitSlot, 1'b0} +: 2];
    hit_ok_s     = hitValid && ({1'b0, hitSlot} < 4'(NUM_SLOTS)) && active_ext_s[hitSlot];
    do_restart_s = (state_r == IDLE) && restart;
    do_pop_s     = (state_r == IDLE) && !restart && hit_ok_s && (hit_level_s == 2'd0);
    do_split_s   = (state_r == IDLE) && !restart && hit_ok_s && (hit_level_s != 2'd0);
    pop_mask_s   = active_r & ~(NUM_SLOTS'(1'b1) << hitSlot);
    free_found_s = 1'b0;
    free_idx_s   = 3'd0;
    // Walk downward so the lowest inactive index wins
    for (int i = NUM_SLOTS - 1; i >= 0; i--) begin
      if (!active_r[i]) begin
        free_found_s = 1'b1;
        free_idx_s   = 3'(i);
      end else begin
        free_found_s = free_found_s;
      end
    end
    x_sum_s   = {1'b0, hit_x_r} + 12'(CHILD_OFFSET);
    right_x_s = (x_sum_s > 12'(X_MAX)) ? 11'(X_MAX) : x_sum_s[10:0];
  end

  // Next-state logic
  always_comb begin
    next_state_s = state_r;
    case (state_r)
      IDLE: begin
        if (do_restart_s)    next_state_s = RESTART;
        else if (do_split_s) next_state_s = LOAD_L;
        else                 next_state_s = IDLE;
      end
      LOAD_L: begin
        if (free_found_s) next_state_s = LOAD_R;
        else              next_state_s = IDLE;
      end
      LOAD_R:  next_state_s = IDLE;
      RESTART: next_state_s = IDLE;
      default: next_state_s = IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) state_r <= IDLE;
    else         state_r <= next_state_s;
  end

  // Slot bookkeeping and bus/strobe registers, updated on entry to each strobe state
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      load_n_r      <= '1;
      active_r      <= NUM_SLOTS'(1'b1);
      level_r       <= LW'(MAX_LEVEL);
      x_r           <= 11'(START_X);
      y_r           <= 11'(START_Y);
      xs_r          <= 16'(START_XSPEED);
      ys_r          <= 16'(START_YSPEED);
      busy_r        <= 1'b0;
      all_cleared_r <= 1'b0;
      hit_x_r       <= 11'd0;
      hit_y_r       <= 11'd0;
      child_level_r <= 2'd0;
    end else begin
      load_n_r      <= '1;
      all_cleared_r <= 1'b0;
      busy_r        <= (next_state_s != IDLE);
      case (state_r)
        IDLE: begin
          if (do_restart_s) begin
            active_r <= NUM_SLOTS'(1'b1);
            level_r  <= LW'(MAX_LEVEL);
            load_n_r <= ~NUM_SLOTS'(1'b1);
            x_r      <= 11'(START_X);
            y_r      <= 11'(START_Y);
            xs_r     <= 16'(START_XSPEED);
            ys_r     <= 16'(START_YSPEED);
          end else if (do_pop_s) begin
            active_r      <= pop_mask_s;
            all_cleared_r <= (pop_mask_s == '0);
          end else if (do_split_s) begin
            hit_x_r       <= hitX;
            hit_y_r       <= hitY;
            child_level_r <= hit_level_s - 2'd1;
            level_r       <= set_level(level_r, hitSlot, hit_level_s - 2'd1);
            load_n_r      <= ~(NUM_SLOTS'(1'b1) << hitSlot);
            x_r           <= hitX;
            y_r           <= hitY;
            xs_r          <= 16'(-SPLIT_XSPEED);
            ys_r          <= 16'(SPLIT_YSPEED);
          end
        end
        LOAD_L: begin
          if (free_found_s) begin
            active_r <= active_r | (NUM_SLOTS'(1'b1) << free_idx_s);
            level_r  <= set_level(level_r, free_idx_s, child_level_r);
            load_n_r <= ~(NUM_SLOTS'(1'b1) << free_idx_s);
            x_r      <= right_x_s;
            y_r      <= hit_y_r;
            xs_r     <= 16'(SPLIT_XSPEED);
            ys_r     <= 16'(SPLIT_YSPEED);
          end
        end
        default: begin
        end
      endcase
    end
  end

`ifdef BALL_SPAWN_SCORE_EN
  logic [15:0] pop_count_r;

  // Saturating count of level-0 pops, cleared by restart
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN)                                 pop_count_r <= 16'd0;
    else if (do_restart_s)                       pop_count_r <= 16'd0;
    else if (do_pop_s && pop_count_r != 16'hFFFF) pop_count_r <= pop_count_r + 16'd1;
  end

  assign popCount = pop_count_r;
`else
  assign popCount = 16'd0;
`endif

  assign loadN         = load_n_r;
  assign initialX      = x_r;
  assign initialY      = y_r;
  assign initialXspeed = xs_r;
  assign initialYspeed = ys_r;
  assign slotActive    = active_r;
  assign slotLevel     = level_r;
  assign busy          = busy_r;
  assign allCleared    = all_cleared_r;

endmodule

// File: tb/tb_ball_spawn_ctrl.sv
// Scoreboard bench for ball_spawn_ctrl: a slot-array model predicts strobes and slot state.
module tb_ball_spawn_ctrl;
  localparam int N = 4;

  logic clk = 1'b0;
  logic resetN, startOfFrame, restart, hitValid;
  logic [2:0] hitSlot;
  logic [10:0] hitX, hitY;
  logic [N-1:0] loadN, slotActive;
  logic [10:0] initialX, initialY;
  logic signed [15:0] initialXspeed, initialYspeed;
  logic [2*N-1:0] slotLevel;
  logic busy, allCleared;
  logic [15:0] popCount;

  ball_spawn_ctrl dut (
    .clk(clk), .resetN(resetN), .startOfFrame(startOfFrame), .restart(restart),
    .hitValid(hitValid), .hitSlot(hitSlot), .hitX(hitX), .hitY(hitY),
    .loadN(loadN), .initialX(initialX), .initialY(initialY),
    .initialXspeed(initialXspeed), .initialYspeed(initialYspeed),
    .slotActive(slotActive), .slotLevel(slotLevel), .busy(busy),
    .allCleared(allCleared), .popCount(popCount)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0]  ln;
    logic [10:0] x;
    logic [10:0] y;
    logic [15:0] xs;
    logic [15:0] ys;
  } strobe_t;

  strobe_t exp_q[$];
  strobe_t last_bus, mon_e, mon_c;
  int n_checks = 0;
  int n_fail = 0;
  int m_active[N];
  int m_level[N];
  int m_pop;

  function automatic strobe_t mk(int slot, int x, int y, int xs, int ys);
    strobe_t s;
    s.ln = 4'hF;
    s.ln[slot] = 1'b0;
    s.x = 11'(x);
    s.y = 11'(y);
    s.xs = 16'(xs);
    s.ys = 16'(ys);
    return s;
  endfunction

  function automatic strobe_t cur_bus();
    return {loadN, initialX, initialY, initialXspeed, initialYspeed};
  endfunction

  task automatic check(string name, logic [63:0] act, logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic void model_reset();
    for (int i = 0; i < N; i++) begin
      m_active[i] = 0;
      m_level[i] = 0;
    end
    m_active[0] = 1;
    m_level[0] = 3;
    m_pop = 0;
    last_bus = mk(0, 100, 100, 64, 0);
    last_bus.ln = 4'hF;
  endfunction

  function automatic logic [N-1:0] exp_active();
    logic [N-1:0] v;
    for (int i = 0; i < N; i++) v[i] = (m_active[i] != 0);
    return v;
  endfunction

  function automatic logic [2*N-1:0] exp_level();
    logic [2*N-1:0] v;
    for (int i = 0; i < N; i++) v[2*i +: 2] = 2'(m_level[i]);
    return v;
  endfunction

  function automatic int exp_pop();
`ifdef BALL_SPAWN_SCORE_EN
    return m_pop;
`else
    return 0;
`endif
  endfunction

  function automatic int any_active();
    for (int i = 0; i < N; i++) if (m_active[i] != 0) return i;
    return -1;
  endfunction

  task automatic push_strobe(strobe_t s);
    exp_q.push_back(s);
    last_bus = s;
    last_bus.ln = 4'hF;
  endtask

  task automatic settled_checks();
    check("slot_active", slotActive, exp_active());
    check("slot_level", slotLevel, exp_level());
    check("busy_idle", busy, 0);
    check("all_cleared_idle", allCleared, 0);
    check("pop_count", popCount, exp_pop());
    check("bus_hold", cur_bus(), last_bus);
  endtask

  task automatic check_reset();
    strobe_t r;
    r = mk(0, 100, 100, 64, 0);
    r.ln = 4'hF;
    check("reset_bus", cur_bus(), r);
    check("reset_active", slotActive, 4'b0001);
    check("reset_level", slotLevel, 8'h03);
    check("reset_busy", busy, 0);
    check("reset_cleared", allCleared, 0);
    check("reset_pop", popCount, 0);
  endtask

  // Drive one hit at a negedge; the model decides split, pop or ignore
  task automatic do_hit(int s, int x, int y, bit hold);
    bit split, clr;
    int lv, f, rx;
    logic [3:0] lmask;
    split = 0;
    clr = 0;
    lmask = 4'hF;
    if (s < N && m_active[s] != 0) begin
      if (m_level[s] == 0) begin
        m_active[s] = 0;
        if (m_pop < 65535) m_pop++;
        clr = (any_active() < 0);
      end else begin
        split = 1;
        lv = m_level[s] - 1;
        m_level[s] = lv;
        push_strobe(mk(s, x, y, -96, -200));
        lmask[s] = 1'b0;
        f = -1;
        for (int i = 0; i < N; i++) if (m_active[i] == 0 && f < 0) f = i;
        if (f >= 0) begin
          m_active[f] = 1;
          m_level[f] = lv;
          rx = (x + 24 > 599) ? 599 : x + 24;
          push_strobe(mk(f, rx, y, 96, -200));
        end
      end
    end
    hitValid = 1'b1;
    hitSlot = 3'(s);
    hitX = 11'(x);
    hitY = 11'(y);
    @(negedge clk);
    check("busy_after_hit", busy, split);
    check("all_cleared_pulse", allCleared, clr);
    check("first_strobe_mask", loadN, lmask);
    if (!(hold && split)) hitValid = 1'b0;
    @(negedge clk);
    hitValid = 1'b0;
    repeat (2) @(negedge clk);
    settled_checks();
  endtask

  task automatic do_restart(bit with_hit, int s);
    model_reset();
    push_strobe(mk(0, 100, 100, 64, 0));
    restart = 1'b1;
    if (with_hit) begin
      hitValid = 1'b1;
      hitSlot = 3'(s);
      hitX = 11'd300;
      hitY = 11'd200;
    end
    @(negedge clk);
    check("busy_restart", busy, 1);
    check("restart_strobe_mask", loadN, 4'b1110);
    restart = 1'b0;
    hitValid = 1'b0;
    repeat (3) @(negedge clk);
    settled_checks();
  endtask

  // Monitor: every strobe seen must match the oldest predicted strobe
  always @(negedge clk) begin
    if (resetN === 1'b1 && loadN !== 4'hF) begin
      n_checks++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL strobe_unexpected: got loadN=%b expected no strobe", loadN);
      end else begin
        mon_e = exp_q.pop_front();
        mon_c = cur_bus();
        if (mon_c !== mon_e) begin
          n_fail++;
          $display("FAIL strobe: got ln=%b x=%0d y=%0d xs=%0d ys=%0d expected ln=%b x=%0d y=%0d xs=%0d ys=%0d",
                   mon_c.ln, mon_c.x, mon_c.y, $signed(mon_c.xs), $signed(mon_c.ys),
                   mon_e.ln, mon_e.x, mon_e.y, $signed(mon_e.xs), $signed(mon_e.ys));
        end
      end
    end
  end

  initial begin
    int s, k, r;
    resetN = 1'b0;
    startOfFrame = 1'b0;
    restart = 1'b0;
    hitValid = 1'b0;
    hitSlot = 3'd0;
    hitX = 11'd0;
    hitY = 11'd0;
    model_reset();
    repeat (3) @(negedge clk);
    check_reset();
    resetN = 1'b1;
    @(negedge clk);
    check_reset();

    do_hit(0, 200, 300, 0);
    check("split_levels", slotLevel, 8'h0A);
    do_hit(1, 590, 40, 0);
    do_hit(0, 10, 20, 1);
    do_hit(2, 123, 77, 0);
    check("full_no_sibling", slotActive, 4'b1111);
    do_hit(6, 5, 5, 0);
    do_restart(1, 1);

    // Reset lands during the right-child strobe cycle
    push_strobe(mk(0, 50, 60, -96, -200));
    hitValid = 1'b1;
    hitSlot = 3'd0;
    hitX = 11'd50;
    hitY = 11'd60;
    @(posedge clk);
    @(negedge clk);
    hitValid = 1'b0;
    @(posedge clk);
    #1 resetN = 1'b0;
    @(negedge clk);
    model_reset();
    check_reset();
    resetN = 1'b1;
    @(negedge clk);
    check_reset();

    for (k = 0; k < 60; k++) begin
      s = any_active();
      if (s < 0) break;
      do_hit(s, $urandom_range(0, 599), $urandom_range(0, 479), 0);
    end
    check("cleared_mask", slotActive, 4'b0000);
    do_hit(0, 1, 1, 0);

    for (k = 0; k < 80; k++) begin
      r = $urandom_range(0, 9);
      if (r == 0) begin
        do_restart($urandom_range(0, 1), $urandom_range(0, 3));
      end else begin
        if (r < 3) s = $urandom_range(0, 7);
        else begin
          s = any_active();
          if (s < 0 || $urandom_range(0, 1) == 1) s = $urandom_range(0, 3);
        end
        do_hit(s, $urandom_range(0, 599), $urandom_range(0, 479), $urandom_range(0, 1));
      end
    end

    repeat (3) @(negedge clk);
    check("queue_drained", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
